forth_bootmem: RTL
==================

FORTH_BOOTMEM -- requirements
Module: forth_bootmem

Interface
REQ-001 SHALL have parameter width, default 16, meaning data-word width.
REQ-002 SHALL have parameter iaddr_width, default 10, meaning instruction address width (imem depth 2^iaddr_width x 16).
REQ-003 SHALL have parameter daddr_width, default 8, meaning data address width (dmem depth 2^daddr_width x width).
REQ-004 SHALL have ports: clk  in  1  clock; reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: iaddr  in  iaddr_width  CPU fetch address; idata  out  16  fetched instruction.
REQ-006 SHALL have ports: daddr  in  daddr_width  CPU data address; ddata_write  in  width  store data; dwrite  in  1  store strobe; ddata_read  out  width  load data.
REQ-007 SHALL have ports: rx_data  in  8  loader byte; rx_valid  in  1  byte offered; rx_ready  out  1  byte accepted when rx_valid & rx_ready.
REQ-008 SHALL have ports: boot_req  in  1  restart load; cpu_reset  out  1  active-high reset to CPU; loading  out  1  load in progress.

Function
REQ-009 idata SHALL equal imem[iaddr sampled at previous clk edge] (one-cycle synchronous read, matching the CPU's registered fetch).
REQ-010 ddata_read SHALL equal dmem[daddr sampled at previous edge]; read-during-write to the same address SHALL return old data.
REQ-011 dmem[daddr] SHALL be written with ddata_write on edge where dwrite=1 and cpu_reset=0; dwrite while cpu_reset=1 SHALL be ignored.
REQ-012 Loader FSM states: LEN_LO, LEN_HI, DAT_LO, DAT_HI, RUN.
REQ-013 rx_ready SHALL be 1 in LEN_LO/LEN_HI/DAT_LO/DAT_HI and 0 in RUN; one byte accepted per handshake cycle; no state change without handshake.
REQ-014 LEN_LO: accepted byte -> count[7:0], go LEN_HI; LEN_HI: byte -> count[15:8], go DAT_LO, or RUN if full 16-bit count = 0.
REQ-015 DAT_LO: byte -> word[7:0], go DAT_HI; DAT_HI: byte -> word[15:8], write {byte, word[7:0]} to imem[waddr], increment waddr, decrement count; go RUN when count reaches 0, else DAT_LO.
REQ-016 waddr SHALL start at 0 each load; words with waddr >= 2^iaddr_width SHALL be consumed but not written (no wrap).
REQ-017 cpu_reset and loading SHALL be 1 in every state except RUN; cpu_reset SHALL fall on the edge entering RUN (first CPU fetch of address 0 follows).
REQ-018 boot_req=1 in RUN SHALL move FSM to LEN_LO next edge; boot_req in load states SHALL be ignored.
REQ-019 A loader imem write and a CPU fetch of the same address in one cycle SHALL return old data (cannot occur in practice; CPU held in reset).
REQ-020 Count arithmetic SHALL be 16-bit unsigned; waddr SHALL be iaddr_width+1 bits to detect overflow.

Reset
REQ-021 reset_n=0 at an edge SHALL force state LEN_LO, waddr=0, count=0, cpu_reset=1, loading=1, rx_ready=1 on the following cycle.
REQ-022 Reset mid-load SHALL abandon the partial load and restart at LEN_LO; imem/dmem contents SHALL NOT be cleared.
REQ-023 idata/ddata_read SHALL have no reset value requirement; memories SHALL not be initialised by reset.

Structure
REQ-024 Shared package forth_pkg SHALL hold OP_NOP (16'he040), instruction width 16, loader state encoding.
REQ-025 One sub-module forth_sdpram (simple dual-port, one write port, one synchronous read port, parameterised width/depth) SHALL be instantiated for imem and dmem.

Verification
REQ-026 Reset then bytes 02 00 34 12 78 56 -> imem[0]=16'h1234, imem[1]=16'h5678, cpu_reset falls after 6th handshake, rx_ready=0.
REQ-027 Bytes 00 00 -> RUN after 2nd handshake, imem unchanged, cpu_reset=0.
REQ-028 rx_valid toggled 1/0 every cycle during 3-word load -> identical imem contents, state stalls on idle cycles.
REQ-029 Load 3 words, reset_n low after 3rd byte, then 01 00 EF BE -> imem[0]=16'hBEEF, imem[1] retains pre-reset value.
REQ-030 In RUN: dwrite=1 daddr=8'h10 data=16'hA5A5, next cycle daddr=8'h10 -> ddata_read=16'hA5A5 one cycle later; dwrite during cpu_reset=1 -> no write.
REQ-031 iaddr_width=2, load count 5 -> imem[0..3] written, 5th word discarded, RUN after 12 handshakes; boot_req in RUN -> cpu_reset=1, rx_ready=1 next cycle.

Source files
------------

// File: rtl/forth_pkg.sv
// Shared definitions for the Forth boot memory: instruction width, canonical NOP
// and the byte-loader state encoding.
package forth_pkg;

    localparam int INSN_WIDTH = 16;
    localparam logic [INSN_WIDTH-1:0] OP_NOP = 16'he040;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DAT_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_RUN    = 3'd4
    } load_state_t;

endpackage

// File: rtl/forth_sdpram.sv
// Simple dual-port RAM: one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module forth_sdpram #(
    parameter int data_width = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [0:(2**addr_width)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/forth_bootmem.sv
// Boot memory for a small Forth CPU: instruction and data RAMs plus a byte-serial
// loader that fills imem and holds the CPU in reset until the image is complete.
//
// state  | meaning
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count
// DAT_LO | waiting for low byte of next instruction word
// DAT_HI | waiting for high byte; word is written on acceptance
// RUN    | load finished, CPU released from reset
module forth_bootmem
    import forth_pkg::*;
#(
    parameter int width       = 16,
    parameter int iaddr_width = 10,
    parameter int daddr_width = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [iaddr_width-1:0] iaddr,
    output logic [INSN_WIDTH-1:0]  idata,
    input  logic [daddr_width-1:0] daddr,
    input  logic [width-1:0]       ddata_write,
    input  logic                   dwrite,
    output logic [width-1:0]       ddata_read,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   boot_req,
    output logic                   cpu_reset,
    output logic                   loading
);

    localparam logic [iaddr_width:0] WADDR_ONE = 1;

    load_state_t          state, state_next;
    logic [15:0]          count, count_next;
    logic [iaddr_width:0] waddr, waddr_next;
    logic [7:0]           word_lo, word_lo_next;
    logic                 accept;
    logic                 imem_we;
    logic                 dmem_we;

    assign rx_ready  = (state != ST_RUN);
    assign cpu_reset = (state != ST_RUN);
    assign loading   = (state != ST_RUN);
    assign accept    = rx_valid && rx_ready;
    assign dmem_we   = dwrite && !cpu_reset;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_LEN_LO;
            count   <= '0;
            waddr   <= '0;
            word_lo <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            waddr   <= waddr_next;
            word_lo <= word_lo_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        waddr_next   = waddr;
        word_lo_next = word_lo;
        imem_we      = 1'b0;
        case (state)
            ST_LEN_LO: begin
                if (accept) begin
                    count_next = {count[15:8], rx_data};
                    waddr_next = '0;
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    count_next = {rx_data, count[7:0]};
                    state_next = ({rx_data, count[7:0]} == 16'd0) ? ST_RUN : ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (accept) begin
                    word_lo_next = rx_data;
                    state_next   = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    // Past the top of imem the address saturates so nothing wraps to 0.
                    imem_we    = !waddr[iaddr_width];
                    if (!waddr[iaddr_width]) begin
                        waddr_next = waddr + WADDR_ONE;
                    end
                    count_next = count - 16'd1;
                    state_next = (count == 16'd1) ? ST_RUN : ST_DAT_LO;
                end
            end
            ST_RUN: begin
                if (boot_req) begin
                    state_next = ST_LEN_LO;
                end
            end
            default: begin
                state_next = ST_LEN_LO;
            end
        endcase
    end

    forth_sdpram #(
        .data_width (INSN_WIDTH),
        .addr_width (iaddr_width)
    ) u_imem (
        .clk     (clk),
        .wr_en   (imem_we),
        .wr_addr (waddr[iaddr_width-1:0]),
        .wr_data ({rx_data, word_lo}),
        .rd_addr (iaddr),
        .rd_data (idata)
    );

    forth_sdpram #(
        .data_width (width),
        .addr_width (daddr_width)
    ) u_dmem (
        .clk     (clk),
        .wr_en   (dmem_we),
        .wr_addr (daddr),
        .wr_data (ddata_write),
        .rd_addr (daddr),
        .rd_data (ddata_read)
    );

endmodule
